// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and 8N1 frame constants.
package uart_pkg;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned STOP_BITS = 1;
    localparam int unsigned IDX_W     = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input, with a selectable reset level.
module uart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling of the synchronised line, one-byte holding
// register and sticky irq/err/ovr status cleared by an Avalon read strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned N_BIT = 2500
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    input  logic                 rx_read,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 status_irq,
    output logic                 status_err,
    output logic                 status_ovr
);

    localparam int unsigned     CW       = $clog2(N_BIT);
    localparam logic [CW-1:0]    CNT_HALF = CW'(N_BIT / 2 - 1);
    localparam logic [CW-1:0]    CNT_FULL = CW'(N_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    uart_state_e          state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [IDX_W-1:0]     idx, idx_d;
    logic [DATA_BITS-1:0] shreg, shreg_d;
    logic                 line;
    logic                 cnt_zero_c;
    logic                 load_c;
    logic                 ferr_c;

    uart_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (line)
    );

    // Frame FSM, bit timer, bit index and shift register state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
        end
    end

    // Next-state logic; the counter only reloads at zero so it never wraps.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        idx_d      = idx;
        shreg_d    = shreg;
        load_c     = 1'b0;
        ferr_c     = 1'b0;
        cnt_zero_c = (cnt == '0);

        case (state)
            ST_IDLE: begin
                if (!line) begin
                    cnt_d   = CNT_HALF;
                    state_d = ST_START;
                end
            end

            ST_START: begin
                if (cnt_zero_c) begin
                    if (!line) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_DATA: begin
                if (cnt_zero_c) begin
                    shreg_d = {line, shreg[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (idx == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_STOP: begin
                if (cnt_zero_c) begin
                    if (line) begin
                        load_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_c  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                end
            end

            ST_BREAK: begin
                if (line) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register and sticky status; a read in the same cycle as a load
    // acknowledges the old byte, so the new one never counts as an overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            status_irq <= 1'b0;
            status_err <= 1'b0;
            status_ovr <= 1'b0;
        end else if (load_c) begin
            rx_data    <= shreg;
            status_irq <= 1'b1;
            status_ovr <= rx_read ? 1'b0 : (status_ovr | status_irq);
            status_err <= rx_read ? 1'b0 : status_err;
        end else if (ferr_c) begin
            status_err <= 1'b1;
            if (rx_read) begin
                status_irq <= 1'b0;
                status_ovr <= 1'b0;
            end
        end else if (rx_read) begin
            status_irq <= 1'b0;
            status_err <= 1'b0;
            status_ovr <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scenario bench for uart_rx at 16 clocks per bit, with a queue of expected bytes.
module tb_uart_rx;

    localparam int unsigned NB = 16;

    logic       clk;
    logic       rst;
    logic       uart_rxd;
    logic       rx_read;
    logic [7:0] rx_data;
    logic       status_irq;
    logic       status_err;
    logic       status_ovr;

    int         pass_cnt;
    int         chk_cnt;
    int         cyc;
    int         rise_cyc;
    logic       irq_q;
    logic [7:0] exp_q[$];

    uart_rx #(
        .N_BIT (NB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rxd   (uart_rxd),
        .rx_read    (rx_read),
        .rx_data    (rx_data),
        .status_irq (status_irq),
        .status_err (status_err),
        .status_ovr (status_ovr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Records the cycle count at which status_irq is first seen high.
    initial irq_q = 1'b0;
    always @(negedge clk) begin
        if (status_irq && !irq_q) rise_cyc = cyc;
        irq_q = status_irq;
    end

    function automatic logic [7:0] sb_pop();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    // Drives one frame starting at a falling clock edge; idles high afterwards.
    task automatic drive_frame(input logic [7:0] b, input logic stop_val,
                               input int stop_len, input bit expect_rx);
        if (expect_rx) exp_q.push_back(b);
        uart_rxd = 1'b0;
        repeat (NB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (NB) @(negedge clk);
        end
        uart_rxd = stop_val;
        repeat (stop_len) @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    task automatic pulse_read();
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_read  = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", rx_data); else pass_cnt++;
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", status_err); else pass_cnt++;
        chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL reset_ovr got=%b exp=0", status_ovr); else pass_cnt++;
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_clean();
        int         start_cyc;
        logic [7:0] exp;
        rise_cyc  = 0;
        start_cyc = cyc;
        drive_frame(8'h55, 1'b1, NB, 1'b1);
        exp = sb_pop();
        chk_cnt++; if (rise_cyc - start_cyc !== 155) $display("FAIL clean_latency got=%0d exp=155", rise_cyc - start_cyc); else pass_cnt++;
        chk_cnt++; if (rx_data !== exp) $display("FAIL clean_data got=%h exp=%h", rx_data, exp); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL clean_err got=%b exp=0", status_err); else pass_cnt++;
        chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL clean_ovr got=%b exp=0", status_ovr); else pass_cnt++;
        pulse_read();
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL clean_read_irq got=%b exp=0", status_irq); else pass_cnt++;
    endtask

    task automatic test_glitch();
        uart_rxd = 1'b0;
        repeat (5) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (200) @(negedge clk);
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL glitch_irq got=%b exp=0", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL glitch_err got=%b exp=0", status_err); else pass_cnt++;
        chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL glitch_ovr got=%b exp=0", status_ovr); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h55) $display("FAIL glitch_data got=%h exp=55", rx_data); else pass_cnt++;
    endtask

    task automatic test_framing();
        logic [7:0] exp;
        drive_frame(8'hA3, 1'b0, 40, 1'b0);
        chk_cnt++; if (status_err !== 1'b1) $display("FAIL ferr_err got=%b exp=1", status_err); else pass_cnt++;
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL ferr_irq got=%b exp=0", status_irq); else pass_cnt++;
        chk_cnt++; if (rx_data !== 8'h55) $display("FAIL ferr_data got=%h exp=55", rx_data); else pass_cnt++;
        repeat (200) @(negedge clk);
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL break_irq got=%b exp=0", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b1) $display("FAIL break_err got=%b exp=1", status_err); else pass_cnt++;
        drive_frame(8'h3C, 1'b1, NB, 1'b1);
        exp = sb_pop();
        chk_cnt++; if (rx_data !== exp) $display("FAIL after_break_data got=%h exp=%h", rx_data, exp); else pass_cnt++;
        chk_cnt++; if (status_irq !== 1'b1) $display("FAIL after_break_irq got=%b exp=1", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b1) $display("FAIL after_break_err_sticky got=%b exp=1", status_err); else pass_cnt++;
        pulse_read();
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL ferr_read_err got=%b exp=0", status_err); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        drive_frame(8'h12, 1'b1, NB, 1'b1);
        drive_frame(8'h34, 1'b1, NB, 1'b1);
        void'(sb_pop());
        exp = sb_pop();
        chk_cnt++; if (status_ovr !== 1'b1) $display("FAIL ovr_flag got=%b exp=1", status_ovr); else pass_cnt++;
        chk_cnt++; if (status_irq !== 1'b1) $display("FAIL ovr_irq got=%b exp=1", status_irq); else pass_cnt++;
        chk_cnt++; if (rx_data !== exp) $display("FAIL ovr_data got=%h exp=%h", rx_data, exp); else pass_cnt++;
        pulse_read();
        chk_cnt++; if (status_irq !== 1'b0) $display("FAIL ovr_read_irq got=%b exp=0", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL ovr_read_err got=%b exp=0", status_err); else pass_cnt++;
        chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL ovr_read_ovr got=%b exp=0", status_ovr); else pass_cnt++;
    endtask

    task automatic test_read_at_load();
        logic [7:0] exp;
        drive_frame(8'h11, 1'b1, NB, 1'b1);
        void'(sb_pop());
        fork
            drive_frame(8'h7E, 1'b1, NB, 1'b1);
            begin
                repeat (154) @(negedge clk);
                rx_read = 1'b1;
                @(negedge clk);
                rx_read = 1'b0;
            end
        join
        exp = sb_pop();
        chk_cnt++; if (status_irq !== 1'b1) $display("FAIL coinc_irq got=%b exp=1", status_irq); else pass_cnt++;
        chk_cnt++; if (rx_data !== exp) $display("FAIL coinc_data got=%h exp=%h", rx_data, exp); else pass_cnt++;
        chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL coinc_ovr got=%b exp=0", status_ovr); else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] exp;
        fork
            drive_frame(8'hFF, 1'b1, NB, 1'b0);
            begin
                repeat (50) @(negedge clk);
                rst = 1'b1;
                #1;
                chk_cnt++; if (rx_data !== 8'h00) $display("FAIL mrst_data got=%h exp=00", rx_data); else pass_cnt++;
                chk_cnt++; if (status_irq !== 1'b0) $display("FAIL mrst_irq got=%b exp=0", status_irq); else pass_cnt++;
                chk_cnt++; if (status_err !== 1'b0) $display("FAIL mrst_err got=%b exp=0", status_err); else pass_cnt++;
                chk_cnt++; if (status_ovr !== 1'b0) $display("FAIL mrst_ovr got=%b exp=0", status_ovr); else pass_cnt++;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        drive_frame(8'h81, 1'b1, NB, 1'b1);
        exp = sb_pop();
        chk_cnt++; if (rx_data !== exp) $display("FAIL post_rst_data got=%h exp=%h", rx_data, exp); else pass_cnt++;
        chk_cnt++; if (status_irq !== 1'b1) $display("FAIL post_rst_irq got=%b exp=1", status_irq); else pass_cnt++;
        chk_cnt++; if (status_err !== 1'b0) $display("FAIL post_rst_err got=%b exp=0", status_err); else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        chk_cnt  = 0;
        rise_cyc = 0;
        rst      = 1'b1;
        uart_rxd = 1'b1;
        rx_read  = 1'b0;
        @(negedge clk);
        test_reset();
        test_clean();
        test_glitch();
        test_framing();
        test_back_to_back();
        test_read_at_load();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
